// File: rtl/trace_buf.sv
// Retirement trace FIFO: captures {pc, instr, rf write} per retiring cycle.
// Define TRACE_STOP_EN to also halt capture after MAX_CYCLES capture cycles.
module trace_buf #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cap_en,
    input  logic [31:0]  pc_i,
    input  logic [31:0]  instr_i,
    input  logic         rf_we_i,
    input  logic [4:0]   rf_wa_i,
    input  logic [31:0]  rf_wd_i,
    input  logic         rd_en,
    output logic [101:0] rd_data,
    output logic         rd_valid,
    output logic         empty,
    output logic         full,
    output logic [15:0]  drop_cnt,
    output logic [31:0]  cycle_cnt,
    output logic         halted
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_CYCLES < 1)
    begin : g_bad_cfg
        $error("trace_buf: DEPTH must be 2^n >= 2, MAX_CYCLES >= 1");
    end

    logic [101:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [101:0]  entry;
    logic          cap;
    logic          pop;
    logic          push;
    logic          drop;
    logic          stop_hit;
    logic          halt_set;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));

    assign entry = {pc_i, instr_i, rf_we_i, rf_wa_i, rf_wd_i};

    assign cap  = cap_en && !halted;
    assign pop  = rd_en && !empty;
    // a pop in the same edge frees the slot the push needs
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

`ifdef TRACE_STOP_EN
    assign stop_hit = (cycle_cnt == 32'(MAX_CYCLES - 1));
`else
    assign stop_hit = 1'b0;
`endif

    assign halt_set = cap && ((instr_i == 32'h0) || stop_hit);

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            drop_cnt  <= '0;
            cycle_cnt <= '0;
            halted    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (cap && cycle_cnt != 32'hFFFF_FFFF) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (halt_set) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: doc/trace_buf.md
TRACE_BUF -- requirements
Module: trace_buf

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 Parameter MAX_CYCLES, default 1000, capture-cycle limit used only when TRACE_STOP_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 cap_en  input  1  capture enable; high while the CPU is running.
REQ-006 pc_i  input  32  PC of the instruction retiring this cycle.
REQ-007 instr_i  input  32  instruction word retiring this cycle.
REQ-008 rf_we_i  input  1  register-file write enable of the retiring instruction.
REQ-009 rf_wa_i  input  5  register-file write address.
REQ-010 rf_wd_i  input  32  register-file write data.
REQ-011 rd_en  input  1  read request from the drain side.
REQ-012 rd_data  output  102  popped entry {pc, instr, we, wa, wd}, MSB first.
REQ-013 rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-014 empty  output  1  FIFO holds 0 entries.
REQ-015 full  output  1  FIFO holds DEPTH entries.
REQ-016 drop_cnt  output  16  count of entries lost to overflow.
REQ-017 cycle_cnt  output  32  count of capture cycles.
REQ-018 halted  output  1  sticky end-of-program flag.

Function
REQ-019 Capture cycle: a rising edge with cap_en=1 and halted=0.
- Each capture cycle builds one entry from the inputs sampled at that edge.
- The entry is pushed unless the FIFO is full.
REQ-020 Full on push: entry discarded; drop_cnt increments, saturating at 0xFFFF; FIFO contents unchanged.
REQ-021 Pop: a rising edge with rd_en=1 and empty=0.
- Removes the oldest entry.
- rd_data is driven from a register updated at that edge and holds the entry from the next cycle until the next pop.
- rd_valid is high for exactly the cycle after the pop.
REQ-022 Empty on read: rd_en with empty=1 is ignored; rd_valid=0; rd_data holds its previous value.
REQ-023 Simultaneous push and pop:
- When full: pop frees a slot; push is accepted with no drop; occupancy stays DEPTH.
- When empty: only the push takes effect.
REQ-024 Pointers: read and write pointers wrap modulo DEPTH.
- An occupancy counter of width log2(DEPTH)+1 derives full and empty combinationally from registered state.
REQ-025 cycle_cnt increments by 1 on every capture cycle, saturating at 0xFFFFFFFF.
REQ-026 halted is set at the edge of a capture cycle with instr_i == 0x00000000.
- The halting entry itself is pushed, subject to REQ-020.
REQ-027 Once halted=1: no further pushes, no cycle_cnt or drop_cnt updates; pops continue normally; halted clears only by reset.
REQ-028 cap_en=0: no push and no cycle_cnt update; pops unaffected.

Reset
REQ-029 rstn low: pointers, occupancy, drop_cnt, cycle_cnt, halted, rd_valid and rd_data are cleared to 0 immediately, independent of clk.
- empty=1 and full=0 during and after reset.
REQ-030 Reset asserted mid-operation discards all stored entries; pops are ignored while rstn=0.
REQ-031 FIFO storage array is not reset; its contents are unobservable until written.

Configuration
REQ-032 Macro TRACE_STOP_EN.
- Defined: halted also sets on the capture cycle where cycle_cnt == MAX_CYCLES-1 before increment, which is the MAX_CYCLES-th capture; that entry is pushed.
- Undefined: only the REQ-026 condition sets halted; MAX_CYCLES is unused.

Verification
REQ-033 Reset release, then 3 capture cycles with pc=0x0,0x4,0x8, instr=0x00500093, then 3 pops.
- Expect 3 rd_valid pulses carrying pc 0x0,0x4,0x8 in order.
- Expect cycle_cnt=3, then empty=1.
REQ-034 DEPTH=16, no pops, 20 capture cycles with nonzero instr.
- Expect full=1 after the 16th push and drop_cnt=4.
- Draining returns the first 16 entries only.
REQ-035 While full, rd_en=1 and a capture in the same cycle.
- Expect drop_cnt unchanged and occupancy 16.
- Expect the new entry to be the last one drained.
REQ-036 Capture with instr=0x00000000 at pc=0x1C, then 5 further capture cycles.
- Expect halted=1 and the 0x1C entry present.
- Expect no later pushes; cycle_cnt frozen.
REQ-037 With TRACE_STOP_EN defined and MAX_CYCLES=8, 10 capture cycles with nonzero instr.
- Expect halted after the 8th capture and cycle_cnt=8.
- Expect 8 entries stored.
REQ-038 rstn pulsed low for 3 ns between clock edges while 5 entries are stored.
- Expect empty=1, halted=0 and counters 0 immediately.
- Expect no rd_valid on a following rd_en.
